// File: rtl/inc_scheduler_pkg.sv
// Shared constants and helpers for the inc_scheduler block.
//
// Contents:
//   Speed*     - structure selector values understood by Inc
//   wrap_next  - round-robin successor of an index in [0, n)
//
// The stage-record struct depends on the counter width and the index width.
// Both are per-instance parameters, so the struct is declared inside
// inc_scheduler, next to the localparams it is built from.
package inc_scheduler_pkg;

    localparam int unsigned SpeedSerial    = 0;
    localparam int unsigned SpeedBrentKung = 1;
    localparam int unsigned SpeedSklansky  = 2;

    function automatic int unsigned wrap_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/inc.sv
// Inc: parallel-prefix incrementer, Z = A + 1 (mod 2^width).
//
// Ports:
//   A   in   width   operand
//   Z   out  width   A + 1, wrapping
//   CO  out  1       carry out, high when A is all-ones
//
// The carry into bit i is the AND of A[i-1:0]. The prefix-AND network is
// selected by `speed`: ripple chain, Brent-Kung or Sklansky.
module Inc
    import inc_scheduler_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned speed = 1
) (
    input  logic [width-1:0] A,
    output logic [width-1:0] Z,
    output logic             CO
);

    localparam int W = int'(width);

    // p[i] ends up as &A[i:0]; every network below rewrites it in place.
    logic [width-1:0] p;

    always_comb begin
        p = A;
        if (speed == SpeedSerial) begin
            for (int i = 1; i < W; i++) begin
                p[i] = p[i] & p[i-1];
            end
        end else if (speed == SpeedSklansky) begin
            // At span s, bit i (with bit s set) joins the top of the lower half of
            // its 2s-block. That partner has bit s clear, so it is not rewritten
            // at this level.
            for (int s = 1; s < W; s = s * 2) begin
                for (int i = 0; i < W; i++) begin
                    if ((i & s) != 0) begin
                        p[i] = p[i] & p[(i & ~(2 * s - 1)) + s - 1];
                    end
                end
            end
        end else begin
            // Brent-Kung up-sweep builds the power-of-two block prefixes.
            for (int s = 1; s < W; s = s * 2) begin
                for (int i = 2 * s - 1; i < W; i += 2 * s) begin
                    p[i] = p[i] & p[i-s];
                end
            end
            // The down-sweep fills in the remaining positions. Spans too large to
            // matter fall out of the inner loop immediately.
            for (int s = W; s >= 1; s = s / 2) begin
                for (int i = 3 * s - 1; i < W; i += 2 * s) begin
                    p[i] = p[i] & p[i-s];
                end
            end
        end
    end

    assign Z  = A ^ {p[width-2:0], 1'b1};
    assign CO = p[width-1];

endmodule

// File: rtl/inc_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
//
// Ports:
//   CLK    in   1      clock
//   RST    in   1      synchronous active-high reset; forces no grant, pointer to 0
//   req_i  in   nreq   request vector (already qualified by the caller)
//   gnt_o  out  nreq   one-hot grant, first request at or above the pointer
//   idx_o  out  IdxW   encoded grant index (0 when vld_o is low)
//   vld_o  out  1      a grant was issued this cycle
//
// After a grant to g the pointer moves to g+1 (wrapping). With no grant it holds.
module rr_arbiter
    import inc_scheduler_pkg::*;
#(
    parameter  int unsigned nreq = 4,
    localparam int unsigned IdxW = $clog2(nreq)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [nreq-1:0] req_i,
    output logic [nreq-1:0] gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            vld_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        // Scan from the pointer upwards, wrapping; keep the first hit.
        for (int unsigned off = 0; off < nreq; off++) begin
            j = 32'(ptr_q) + off;
            if (j >= nreq) begin
                j = j - nreq;
            end
            if (!vld_o && req_i[j] && !RST) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
        ptr_d = vld_o ? IdxW'(wrap_next(32'(idx_o), nreq)) : ptr_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inc_scheduler.sv
// inc_scheduler: shares one Inc among nreq event counters.
//
// Ports:
//   CLK   in   1            clock, rising edge
//   RST   in   1            synchronous active-high reset
//   REQ   in   nreq         increment request per counter, held until granted
//   CLR   in   nreq         synchronous clear per counter, beats REQ and writeback
//   GNT   out  nreq         one-hot grant (combinational); REQ&GNT accepts an increment
//   CNT   out  nreq*width   registered counters, counter i at CNT[i*width +: width]
//   OVF   out  nreq         sticky wrap flag per counter
//   BUSY  out  1            an increment is in stage 1 or stage 2
//
// Pipeline: a grant at edge t loads stage 1 with the index and the current
// value; Inc runs on stage 1 and its result is captured into stage 2 at t+1;
// stage 2 writes the counter bank at t+2. Operands are forwarded from stage 1
// (Inc output) and stage 2 so back-to-back grants to one counter count exactly.
module inc_scheduler
    import inc_scheduler_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned speed = 1,
    parameter int unsigned nreq  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [nreq-1:0]       REQ,
    input  logic [nreq-1:0]       CLR,
    output logic [nreq-1:0]       GNT,
    output logic [nreq*width-1:0] CNT,
    output logic [nreq-1:0]       OVF,
    output logic                  BUSY
);

    localparam int unsigned IDX_W = $clog2(nreq);

    // Stage 1 carries the operand; stage 2 reuses `op` for the Inc result.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [width-1:0] op;
    } stage_t;

    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    logic   s2_wrap_q, s2_wrap_d;

    logic [nreq-1:0][width-1:0] cnt_q, cnt_d;
    logic [nreq-1:0]            ovf_q, ovf_d;

    logic [nreq-1:0]  eligible;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic [width-1:0] inc_z;
    logic             inc_co;
    logic             s1_live;
    logic             s2_live;

    assign eligible = REQ & ~CLR;

    rr_arbiter #(
        .nreq (nreq)
    ) u_arb (
        .CLK   (CLK),
        .RST   (RST),
        .req_i (eligible),
        .gnt_o (GNT),
        .idx_o (gnt_idx),
        .vld_o (gnt_vld)
    );

    Inc #(
        .width (width),
        .speed (speed)
    ) u_inc (
        .A  (s1_q.op),
        .Z  (inc_z),
        .CO (inc_co)
    );

    // An op survives the current edge only if its counter is not being cleared.
    assign s1_live = s1_q.vld & ~CLR[s1_q.idx];
    assign s2_live = s2_q.vld & ~CLR[s2_q.idx];

    always_comb begin
        s1_d     = '0;
        s1_d.vld = gnt_vld;
        s1_d.idx = gnt_idx;
        // Newest in-flight value for the granted counter wins.
        if (s1_live && s1_q.idx == gnt_idx) begin
            s1_d.op = inc_z;
        end else if (s2_live && s2_q.idx == gnt_idx) begin
            s1_d.op = s2_q.op;
        end else begin
            s1_d.op = cnt_q[gnt_idx];
        end

        s2_d.vld  = s1_live;
        s2_d.idx  = s1_q.idx;
        s2_d.op   = inc_z;
        s2_wrap_d = inc_co;

        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (s2_live) begin
            cnt_d[s2_q.idx] = s2_q.op;
            ovf_d[s2_q.idx] = ovf_q[s2_q.idx] | s2_wrap_q;
        end
        for (int i = 0; i < int'(nreq); i++) begin
            if (CLR[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s2_wrap_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s2_wrap_q <= s2_wrap_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign CNT  = cnt_q;
    assign OVF  = ovf_q;
    assign BUSY = s1_q.vld | s2_q.vld;

endmodule

// File: tb/tb_inc_scheduler.sv
// Self-checking bench for inc_scheduler (width=8, nreq=4).
// A count-level model (per-counter integers plus a list of pending increments
// with due cycles) is compared against the DUT on every falling edge; directed
// phases add literal expectations, then a randomized phase runs.
module tb_inc_scheduler;

    localparam int W      = 8;
    localparam int N      = 4;
    localparam int MaxVal = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, clr, gnt, ovf;
    logic [N*W-1:0] cnt;
    logic           busy;

    always #5 clk = ~clk;

    inc_scheduler #(
        .width (W),
        .speed (1),
        .nreq  (N)
    ) dut (
        .CLK  (clk),
        .RST  (rst),
        .REQ  (req),
        .CLR  (clr),
        .GNT  (gnt),
        .CNT  (cnt),
        .OVF  (ovf),
        .BUSY (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int cnt_of(input int i);
        return int'(cnt[i*W +: W]);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        int idx;
        int due;
    } op_t;

    int  m_cnt[N];
    bit  m_ovf[N];
    int  m_ptr;
    int  cyc   = 0;
    bit  armed = 1'b0;
    op_t pend[$];

    function automatic int m_pick();
        for (int off = 0; off < N; off++) begin
            int j;
            j = (m_ptr + off) % N;
            if (req[j] && !clr[j] && !rst) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int  g;
        op_t keep[$];
        keep.delete();
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end
            m_ptr = 0;
            pend.delete();
            armed = 1'b1;
        end else begin
            g = m_pick();
            foreach (pend[k]) begin
                if (clr[pend[k].idx]) continue;
                if (pend[k].due == cyc) begin
                    if (m_cnt[pend[k].idx] == MaxVal) m_ovf[pend[k].idx] = 1'b1;
                    m_cnt[pend[k].idx] = (m_cnt[pend[k].idx] + 1) % (MaxVal + 1);
                end else begin
                    keep.push_back(pend[k]);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (clr[i]) begin
                    m_cnt[i] = 0;
                    m_ovf[i] = 1'b0;
                end
            end
            pend = keep;
            if (g >= 0) begin
                pend.push_back('{idx: g, due: cyc + 2});
                m_ptr = (g + 1) % N;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (armed) begin
            int g;
            int exp_ovf;
            g = m_pick();
            check("m_gnt", int'(gnt), (g >= 0) ? (1 << g) : 0);
            check("m_busy", int'(busy), (pend.size() != 0) ? 1 : 0);
            exp_ovf = 0;
            for (int i = 0; i < N; i++) begin
                check($sformatf("m_cnt%0d", i), cnt_of(i), m_cnt[i]);
                if (m_ovf[i]) exp_ovf |= (1 << i);
            end
            check("m_ovf", int'(ovf), exp_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] c, input logic rs);
        @(posedge clk);
        #1;
        req = r;
        clr = c;
        rst = rs;
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick('0, '0, 1'b0);
    endtask

    initial begin
        int exp_c0[7];
        int exp_order[8];
        int busy_cycles;
        int pos;
        logic [N-1:0] r, c;

        exp_c0    = '{0, 0, 0, 1, 2, 3, 3};
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        rst = 1'b1;
        req = '0;
        clr = '0;

        // Reset values.
        do_reset();
        check("rst_cnt", int'(cnt == '0), 1);
        check("rst_ovf", int'(ovf), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gnt", int'(gnt), 0);

        // Single requester held for three cycles.
        busy_cycles = 0;
        for (int k = 0; k < 7; k++) begin
            tick((k < 3) ? 4'b0001 : 4'b0000, '0, 1'b0);
            if (k < 3) check("t1_gnt", int'(gnt), 1);
            check("t1_cnt0", cnt_of(0), exp_c0[k]);
            if (busy) busy_cycles++;
        end
        check("t1_busy_len", busy_cycles, 4);

        // All four requesting from pointer 0.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick(4'b1111, '0, 1'b0);
            check("t2_order", int'(gnt), 1 << exp_order[k]);
        end
        idle(3);
        for (int i = 0; i < N; i++) check("t2_cnt", cnt_of(i), 2);

        // Wrap of counter 2.
        do_reset();
        for (int k = 0; k < 254; k++) tick(4'b0100, '0, 1'b0);
        idle(3);
        check("t3_pre", cnt_of(2), 254);
        tick(4'b0100, '0, 1'b0);
        idle(3);
        check("t3_ff", cnt_of(2), 255);
        check("t3_ovf0", int'(ovf[2]), 0);
        tick(4'b0100, '0, 1'b0);
        idle(3);
        check("t3_wrap", cnt_of(2), 0);
        check("t3_ovf1", int'(ovf[2]), 1);
        idle(5);
        check("t3_sticky", int'(ovf[2]), 1);

        // Clear squashes an op sitting in stage 1.
        do_reset();
        tick(4'b0010, '0, 1'b0);
        tick(4'b0010, '0, 1'b0);
        idle(3);
        check("t4_pre", cnt_of(1), 2);
        tick(4'b0010, '0, 1'b0);
        tick('0, 4'b0010, 1'b0);
        idle(3);
        check("t4_cnt1", cnt_of(1), 0);
        check("t4_ovf1", int'(ovf[1]), 0);

        // REQ and CLR on the same counter; another counter still served.
        do_reset();
        tick(4'b1000, '0, 1'b0);
        idle(3);
        check("t5_pre", cnt_of(3), 1);
        tick(4'b1001, 4'b1000, 1'b0);
        check("t5_gnt", int'(gnt), 1);
        idle(3);
        check("t5_cnt3", cnt_of(3), 0);
        check("t5_cnt0", cnt_of(0), 1);

        // Reset with both stages occupied.
        do_reset();
        tick(4'b1111, '0, 1'b0);
        tick(4'b1111, '0, 1'b0);
        tick('0, '0, 1'b1);
        check("t6_gnt_in_rst", int'(gnt), 0);
        tick('0, '0, 1'b0);
        check("t6_cnt", int'(cnt == '0), 1);
        check("t6_busy", int'(busy), 0);
        check("t6_ovf", int'(ovf), 0);
        tick(4'b1111, '0, 1'b0);
        check("t6_ptr0", int'(gnt), 1);
        idle(3);
        check("t6_restart", cnt_of(0), 1);
        check("t6_other", cnt_of(1), 0);

        // Randomized traffic: phases alternate between one dominant requester
        // (back-to-back same-index grants) and general mixes.
        pos = 0;
        for (int k = 0; k < 3000; k++) begin
            if (((k / 60) % 2) == 0) begin
                pos = $urandom_range(0, N - 1);
                r   = ($urandom_range(0, 3) != 0) ? 4'(1 << pos) : 4'($urandom_range(0, 15));
            end else begin
                r = 4'($urandom_range(0, 15));
            end
            c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            tick(r, c, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
